// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by the 1 Hz tick; counts a loaded value down to 00:00,
// then holds and raises done until start_stop returns it to idle.
module countdown_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start_stop,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic       tick_q;
  logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       sec_pulse, count_zero, count_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign sec_pulse  = tick & ~tick_q;
  assign count_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign count_one  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

  // One-second BCD borrow chain; never applied to 00:00.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q - 4'd1;
    if (so_q == 4'd0) begin
      dec_so = 4'd9;
      if (st_q == 4'd0) begin
        dec_st = 4'd5;
        if (mo_q == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = mt_q - 4'd1;
        end else begin
          dec_mo = mo_q - 4'd1;
        end
      end else begin
        dec_st = st_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    if (load) begin
      mt_d    = clamp(load_value[15:12], 4'd9);
      mo_d    = clamp(load_value[11:8], 4'd9);
      st_d    = clamp(load_value[7:4], 4'd5);
      so_d    = clamp(load_value[3:0], 4'd9);
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_stop && !count_zero) state_d = StRun;
        end
        StRun: begin
          if (sec_pulse) begin
            mt_d = dec_mt;
            mo_d = dec_mo;
            st_d = dec_st;
            so_d = dec_so;
          end
          // Reaching zero outranks a simultaneous pause request.
          if (sec_pulse && count_one) begin
            state_d = StDone;
          end else if (start_stop) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (start_stop) state_d = StRun;
        end
        StDone: begin
          if (start_stop) state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      tick_q  <= 1'b1;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign running  = (state_q == StRun);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: a seconds-based reference model queues the expected
// outputs per cycle and a monitor compares them after each clock edge.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        load;
  logic [15:0] load_value;
  logic        start_stop;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        running, done;

  countdown_timer dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start_stop (start_stop),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected output word: {mm_tens, mm_ones, ss_tens, ss_ones, running, done}.
  logic [17:0] exp_q[$];

  // Reference model: remaining time as plain seconds, mode 0 idle, 1 run, 2 pause, 3 done.
  int   m_sec;
  int   m_mode;
  logic m_prev;
  logic tick_lvl;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int to_seconds(input logic [15:0] v);
    int mt, mo, st, so;
    mt = min_int(int'(v[15:12]), 9);
    mo = min_int(int'(v[11:8]), 9);
    st = min_int(int'(v[7:4]), 5);
    so = min_int(int'(v[3:0]), 9);
    return mt * 600 + mo * 60 + st * 10 + so;
  endfunction

  function automatic logic [17:0] model_word();
    logic [3:0] mt, mo, st, so;
    mt = 4'(m_sec / 600);
    mo = 4'((m_sec / 60) % 10);
    st = 4'((m_sec % 60) / 10);
    so = 4'(m_sec % 10);
    return {mt, mo, st, so, (m_mode == 1), (m_mode == 3)};
  endfunction

  task automatic check_out(input string name, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h%h:%h%h running=%b done=%b, expected %h%h:%h%h running=%b done=%b",
               name, $time, got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [17:0] dut_word();
    return {min_tens, min_ones, sec_tens, sec_ones, running, done};
  endfunction

  // Drive one cycle of inputs now and queue what the outputs must be after the next edge.
  task automatic apply(input logic l, input logic [15:0] lv, input logic s, input logic t);
    logic pulse;
    load       = l;
    load_value = lv;
    start_stop = s;
    tick       = t;
    tick_lvl   = t;
    pulse      = t && !m_prev;
    m_prev     = t;
    if (l) begin
      m_sec  = to_seconds(lv);
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (s && m_sec != 0) m_mode = 1;
        1: begin
          if (pulse) m_sec = m_sec - 1;
          if (pulse && m_sec == 0) m_mode = 3;
          else if (s) m_mode = 2;
        end
        2: if (s) m_mode = 1;
        default: if (s) m_mode = 0;
      endcase
    end
    exp_q.push_back(model_word());
  endtask

  task automatic step(input logic l, input logic [15:0] lv, input logic s, input logic t);
    @(negedge clk);
    apply(l, lv, s, t);
  endtask

  task automatic idle_step();
    step(1'b0, 16'h0000, 1'b0, tick_lvl);
  endtask

  // One rising tick edge, optionally with start_stop on the edge cycle.
  task automatic tick_edge(input logic s);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, s, 1'b1);
  endtask

  task automatic model_reset();
    m_sec  = 0;
    m_mode = 0;
    m_prev = 1'b1;
  endtask

  // Assert reset between edges, check outputs clear without a clock, then release.
  task automatic do_reset(input logic t);
    idle_step();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", dut_word(), 18'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(1'b0, 16'h0000, 1'b0, t);
  endtask

  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("outputs", dut_word(), e);
      end
    end
  end

  initial begin : stimulus
    logic [15:0] lv;
    logic        l, s, t;
    reset      = 1'b1;
    tick       = 1'b1;
    tick_lvl   = 1'b1;
    load       = 1'b0;
    load_value = 16'h0000;
    start_stop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_out("in_reset", dut_word(), 18'h0);
    // Release with tick held high: no edge may be seen.
    reset = 1'b0;
    apply(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h0003, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    repeat (4) idle_step();

    // Load and count 00:12 to zero, plus one extra edge.
    step(1'b1, 16'h0012, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (13) tick_edge(1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);  // DONE exit
    idle_step();

    // Start at zero stays idle.
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    idle_step();

    // Borrow chain.
    step(1'b1, 16'h1000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    tick_edge(1'b0);
    repeat (60) tick_edge(1'b0);

    // Pause with a simultaneous edge, hold, then resume together with an edge.
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (2) tick_edge(1'b0);
    tick_edge(1'b1);
    repeat (3) tick_edge(1'b0);
    tick_edge(1'b1);
    repeat (2) tick_edge(1'b0);

    // Load beats start_stop and tick, and sanitises digits.
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'hAF7C, 1'b1, 1'b1);
    repeat (2) tick_edge(1'b0);

    // Asynchronous reset mid-count at 00:07.
    step(1'b1, 16'h0010, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (3) tick_edge(1'b0);
    do_reset(1'b1);
    repeat (3) idle_step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      l = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) lv = 16'($urandom);
      else lv = 16'($urandom_range(0, 25));
      s = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 2) == 0) ? ~tick_lvl : tick_lvl;
      step(l, lv, s, t);
      if (i == 1500) do_reset(tick_lvl);
    end

    idle_step();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
